// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Front-end fetch stage. Reads a 16-bit little-endian
//               instruction as two consecutive bytes from the 8-bit data
//               memory at the instruction pointer. It presents the
//               instruction to decode over a valid/ready handshake. When
//               control retires the instruction, it advances the IP by 2 or
//               by a signed jump offset.
// Ports       : clk, reset (async, active-high)
//               start, halt                 - run control
//               mem_rd_en, mem_addr,
//               mem_rd_data                 - memory read port (1-cycle latency)
//               instr, instr_valid,
//               instr_ready                 - decode handshake
//               next_instr, jump_valid,
//               jump_offset                 - retire / IP update from control
//               ip, busy                    - status
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                   ADDR_BITS        = 8,
    parameter int                   DATA_BITS        = 8,
    parameter int                   JUMP_OFFSET_BITS = 8,
    parameter logic [ADDR_BITS-1:0] RESET_IP         = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        halt,
    output logic                        mem_rd_en,
    output logic [ADDR_BITS-1:0]        mem_addr,
    input  logic [DATA_BITS-1:0]        mem_rd_data,
    output logic [2*DATA_BITS-1:0]      instr,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    input  logic                        next_instr,
    input  logic                        jump_valid,
    input  logic [JUMP_OFFSET_BITS-1:0] jump_offset,
    output logic [ADDR_BITS-1:0]        ip,
    output logic                        busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ_LO    = 3'd1,
        S_REQ_HI    = 3'd2,
        S_CAPTURE   = 3'd3,
        S_HOLD      = 3'd4,
        S_WAIT_NEXT = 3'd5
    } state_t;

    localparam logic [ADDR_BITS-1:0] c_ip_step = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] c_one     = ADDR_BITS'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_BITS-1:0]     r_ip;
    logic [ADDR_BITS-1:0]     w_ip_next;
    logic [ADDR_BITS-1:0]     w_jump_ext;
    logic [2*DATA_BITS-1:0]   r_instr;
    logic                     r_instr_valid;
    logic                     r_mem_rd_en;
    logic [ADDR_BITS-1:0]     r_mem_addr;

    // Sign-extend the offset to IP width. The IP add then wraps modulo
    // 2^ADDR_BITS.
    assign w_jump_ext = ADDR_BITS'($signed(jump_offset));

    always_comb begin
        w_state_next = r_state;
        w_ip_next    = r_ip;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_REQ_LO;
            S_REQ_LO:    w_state_next = S_REQ_HI;
            S_REQ_HI:    w_state_next = S_CAPTURE;
            S_CAPTURE:   w_state_next = S_HOLD;
            S_HOLD:      if (r_instr_valid && instr_ready) w_state_next = S_WAIT_NEXT;
            S_WAIT_NEXT: begin
                if (next_instr) begin
                    // The offset is relative to the retired instruction's
                    // address, not to ip+2.
                    w_ip_next    = jump_valid ? (r_ip + w_jump_ext) : (r_ip + c_ip_step);
                    w_state_next = halt ? S_IDLE : S_REQ_LO;
                end
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ip          <= RESET_IP;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ip    <= w_ip_next;

            // The read strobe and address are registered from the next
            // state. They line up with REQ_LO/REQ_HI, and the data arrives
            // one state later. When entering REQ_LO from WAIT_NEXT, the
            // freshly updated IP must be used, hence w_ip_next.
            r_mem_rd_en <= (w_state_next == S_REQ_LO) || (w_state_next == S_REQ_HI);
            if (w_state_next == S_REQ_LO)
                r_mem_addr <= w_ip_next;
            else if (w_state_next == S_REQ_HI)
                r_mem_addr <= r_ip + c_one;

            if (r_state == S_REQ_HI)
                r_instr[DATA_BITS-1:0] <= mem_rd_data;

            if (r_state == S_CAPTURE) begin
                r_instr[2*DATA_BITS-1:DATA_BITS] <= mem_rd_data;
                r_instr_valid                    <= 1'b1;
            end else if ((r_state == S_HOLD) && instr_ready) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign ip          = r_ip;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. It uses a
//               byte-wide synchronous memory model with one-cycle read
//               latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        next_instr;
    logic        jump_valid;
    logic [7:0]  jump_offset;
    logic [7:0]  ip;
    logic        busy;

    logic [7:0]  mem [256];
    int          errors = 0;
    int          checks = 0;

    instr_fetch_unit #(
        .ADDR_BITS        (8),
        .DATA_BITS        (8),
        .JUMP_OFFSET_BITS (8),
        .RESET_IP         (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .next_instr  (next_instr),
        .jump_valid  (jump_valid),
        .jump_offset (jump_offset),
        .ip          (ip),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // Stimulus helpers. They do no result checking beyond a timeout.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s: instr_valid timeout, got %0b want 1", name, instr_valid);
        end
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic retire(input logic jv, input logic [7:0] off, input logic h);
        next_instr  = 1'b1;
        jump_valid  = jv;
        jump_offset = off;
        halt        = h;
        @(negedge clk);
        next_instr  = 1'b0;
        jump_valid  = 1'b0;
        jump_offset = 8'h00;
        halt        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ip, instr, instr_valid, mem_rd_en, mem_addr, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: ip=%h instr=%h v=%b rd=%b addr=%h busy=%b want all 0",
                     ip, instr, instr_valid, mem_rd_en, mem_addr, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rd=%b want 0 0", busy, mem_rd_en);
        end
    endtask

    task automatic test_basic_fetch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL req_lo: rd=%b addr=%h want 1 00", mem_rd_en, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL req_hi: rd=%b addr=%h want 1 01", mem_rd_en, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture: rd=%b v=%b want 0 0", mem_rd_en, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1234 || ip !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_instr: v=%b instr=%h ip=%h busy=%b want 1 1234 00 1",
                     instr_valid, instr, ip, busy);
        end
    endtask

    task automatic test_hold_and_advance();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h1234) begin
                errors++;
                $display("FAIL hold_stable[%0d]: v=%b instr=%h want 1 1234", i, instr_valid, instr);
            end
        end
        accept();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h1234) begin
            errors++;
            $display("FAIL handshake: v=%b instr=%h want 0 1234", instr_valid, instr);
        end
        retire(1'b0, 8'h00, 1'b0);
        checks++;
        if (ip !== 8'h02 || mem_rd_en !== 1'b1 || mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL advance_ip: ip=%h rd=%b addr=%h want 02 1 02", ip, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'h03) begin
            errors++;
            $display("FAIL advance_hi: rd=%b addr=%h want 1 03", mem_rd_en, mem_addr);
        end
        wait_valid("advance");
        checks++;
        if (instr !== 16'h5678) begin
            errors++;
            $display("FAIL advance_instr: instr=%h want 5678", instr);
        end
    endtask

    task automatic test_jump();
        accept();
        retire(1'b1, 8'h0E, 1'b0);
        checks++;
        if (ip !== 8'h10) begin
            errors++;
            $display("FAIL jump_fwd: ip=%h want 10", ip);
        end
        wait_valid("jump1");
        accept();
        retire(1'b1, 8'hF0, 1'b0);
        checks++;
        if (ip !== 8'h00 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL jump_neg: ip=%h addr=%h want 00 00", ip, mem_addr);
        end
        wait_valid("jump2");
        checks++;
        if (instr !== 16'h1234) begin
            errors++;
            $display("FAIL jump_neg_instr: instr=%h want 1234", instr);
        end
        accept();
        retire(1'b1, 8'h10, 1'b0);
        wait_valid("jump3");
        accept();
        retire(1'b1, 8'h7F, 1'b0);
        checks++;
        if (ip !== 8'h8F || mem_addr !== 8'h8F) begin
            errors++;
            $display("FAIL jump_max: ip=%h addr=%h want 8f 8f", ip, mem_addr);
        end
    endtask

    task automatic test_wrap();
        wait_valid("wrap0");
        accept();
        retire(1'b1, 8'h70, 1'b0);
        checks++;
        if (ip !== 8'hFF || mem_addr !== 8'hFF || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL wrap_lo: ip=%h addr=%h rd=%b want ff ff 1", ip, mem_addr, mem_rd_en);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h00 || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hi: addr=%h rd=%b want 00 1", mem_addr, mem_rd_en);
        end
        wait_valid("wrap1");
        checks++;
        if (instr !== 16'h34AB) begin
            errors++;
            $display("FAIL wrap_instr: instr=%h want 34ab", instr);
        end
        accept();
        retire(1'b1, 8'hFF, 1'b0);
        checks++;
        if (ip !== 8'hFE) begin
            errors++;
            $display("FAIL jump_minus1: ip=%h want fe", ip);
        end
        wait_valid("wrap2");
        checks++;
        if (instr !== 16'hABCD) begin
            errors++;
            $display("FAIL fe_instr: instr=%h want abcd", instr);
        end
        accept();
        retire(1'b0, 8'h00, 1'b0);
        checks++;
        if (ip !== 8'h00) begin
            errors++;
            $display("FAIL wrap_step: ip=%h want 00", ip);
        end
    endtask

    task automatic test_halt_resume();
        wait_valid("halt0");
        accept();
        retire(1'b0, 8'h00, 1'b1);
        checks++;
        if (ip !== 8'h02 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL halt: ip=%h busy=%b rd=%b want 02 0 0", ip, busy, mem_rd_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL halted_idle[%0d]: busy=%b rd=%b want 0 0", i, busy, mem_rd_en);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'h02 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resume: rd=%b addr=%h busy=%b want 1 02 1", mem_rd_en, mem_addr, busy);
        end
        wait_valid("resume");
        checks++;
        if (instr !== 16'h5678) begin
            errors++;
            $display("FAIL resume_instr: instr=%h want 5678", instr);
        end
    endtask

    task automatic test_stray_inputs();
        // A next_instr that coincides with the handshake must not retire.
        instr_ready = 1'b1;
        next_instr  = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        next_instr  = 1'b0;
        @(negedge clk);
        checks++;
        if (ip !== 8'h02 || busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL hs_next_ignored: ip=%h busy=%b rd=%b want 02 1 0", ip, busy, mem_rd_en);
        end
        retire(1'b0, 8'h00, 1'b0);
        checks++;
        if (ip !== 8'h04 || mem_addr !== 8'h04) begin
            errors++;
            $display("FAIL stray_pre: ip=%h addr=%h want 04 04", ip, mem_addr);
        end
        @(negedge clk);
        start       = 1'b1;
        next_instr  = 1'b1;
        jump_valid  = 1'b1;
        jump_offset = 8'h40;
        @(negedge clk);
        start       = 1'b0;
        next_instr  = 1'b0;
        jump_valid  = 1'b0;
        jump_offset = 8'h00;
        checks++;
        if (ip !== 8'h04 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stray_ignored: ip=%h rd=%b want 04 0", ip, mem_rd_en);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h9ABC) begin
            errors++;
            $display("FAIL stray_instr: v=%b instr=%h want 1 9abc", instr_valid, instr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        accept();
        retire(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ip, instr, instr_valid, mem_rd_en, mem_addr, busy} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: ip=%h instr=%h v=%b rd=%b addr=%h busy=%b want all 0",
                     ip, instr, instr_valid, mem_rd_en, mem_addr, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_data: instr=%h v=%b busy=%b want 0000 0 0", instr, instr_valid, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78; mem[8'h03] = 8'h56;
        mem[8'h04] = 8'hBC; mem[8'h05] = 8'h9A;
        mem[8'h06] = 8'hEF;
        mem[8'hFE] = 8'hCD; mem[8'hFF] = 8'hAB;
        mem_rd_data = 8'h00;
        reset       = 1'b1;
        start       = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        next_instr  = 1'b0;
        jump_valid  = 1'b0;
        jump_offset = 8'h00;
        @(negedge clk);

        test_reset();
        test_basic_fetch();
        test_hold_and_advance();
        test_jump();
        test_wrap();
        test_halt_resume();
        test_stray_inputs();
        test_reset_mid_fetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage of the processor.
- Reads one 16-bit instruction as two consecutive bytes from the 8-bit data memory, starting at the instruction pointer (IP).
- Hands the instruction to the decode/register-fetch stage over a valid/ready handshake.
- Advances the IP by 2, or by a signed jump offset, when the control unit signals that the instruction has completed.

Parameters:
- ADDR_BITS, 8, memory address width; equals IP width (MEMORY_ADDRESS_BITS / INSTRUCTION_POINTER_BITS).
- DATA_BITS, 8, memory data width (MEMORY_DATA_BITS).
- JUMP_OFFSET_BITS, 8, signed jump offset width.
- RESET_IP, 0, IP value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at current IP.
- halt  in  1  sampled with next_instr; return to IDLE after IP update.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_BITS  memory read address.
- mem_rd_data  in  DATA_BITS  read data; valid exactly one cycle after mem_rd_en.
- instr  out  2*DATA_BITS  fetched instruction {hi byte, lo byte}.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode accepts instr.
- next_instr  in  1  one-cycle pulse from control: current instruction retired.
- jump_valid  in  1  qualifies next_instr: take the jump.
- jump_offset  in  JUMP_OFFSET_BITS  two's-complement offset.
- ip  out  ADDR_BITS  address of the current or last fetched instruction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async): state=IDLE, ip=RESET_IP, instr=0, instr_valid=0, mem_rd_en=0, mem_addr=0, busy=0. Reset mid-fetch aborts the fetch; any in-flight read data is ignored.
- Byte order: little-endian. Lo byte at ip, hi byte at ip+1.
- States and transitions:
  - IDLE: start -> REQ_LO; otherwise stay.
  - REQ_LO: mem_rd_en=1, mem_addr=ip -> REQ_HI.
  - REQ_HI: mem_rd_en=1, mem_addr=ip+1 (mod 2^ADDR_BITS); latch mem_rd_data into instr[7:0] -> CAPTURE.
  - CAPTURE: mem_rd_en=0; latch mem_rd_data into instr[15:8]; set instr_valid at the edge -> HOLD.
  - HOLD: instr_valid=1, instr stable. On instr_valid&&instr_ready: clear instr_valid -> WAIT_NEXT.
  - WAIT_NEXT: on next_instr:
    - jump_valid=1: ip <= ip + sign_extend(jump_offset).
    - jump_valid=0: ip <= ip + 2.
    - Then -> IDLE if halt, else REQ_LO.
- Latency: start sampled at edge k -> mem_rd_en high in cycles k+1 and k+2 -> instr_valid high from cycle k+4.
- mem_rd_en and mem_addr are registered outputs, driven from the state. Outside REQ_LO/REQ_HI: mem_rd_en=0 and mem_addr holds its last value.
- IP arithmetic is modulo 2^ADDR_BITS; no overflow flag.
  - ip=0xFF: hi byte read from 0x00.
  - ip=0xFE with no jump -> 0x00.
  - Jump offset is relative to the address of the retired instruction, not ip+2.
- Ignored inputs:
  - start outside IDLE.
  - next_instr outside WAIT_NEXT, including a next_instr coincident with the HOLD handshake.
  - instr_ready while instr_valid=0.
  - halt without next_instr.
- instr retains its value after the handshake until overwritten in REQ_HI/CAPTURE.
- busy=1 in REQ_LO, REQ_HI, CAPTURE, HOLD and WAIT_NEXT.

Test Plan:
- Reset, mem[0]=0x34, mem[1]=0x12, pulse start -> mem_rd_en high 2 cycles at addr 0x00 then 0x01; instr=0x1234 and instr_valid=1 four cycles after start; ip=0x00.
- Hold instr_ready low 5 cycles in HOLD -> instr_valid and instr stay constant. Raise ready, then next_instr with jump_valid=0 -> ip=0x02; reads at 0x02 and 0x03 follow.
- ip=0x10, next_instr with jump_valid=1 and jump_offset=0xF0 (-16) -> ip=0x00. With offset 0x7F -> ip=0x8F.
- ip=0xFF -> reads at 0xFF then 0x00. ip=0xFE with no jump -> next ip=0x00.
- next_instr with halt=1 -> ip updated, busy=0, no mem_rd_en. Later start -> fetch resumes at the updated ip. Stray start/next_instr pulses during REQ_HI have no effect.
- Assert reset during REQ_HI -> all outputs return to reset values immediately; the stale read byte does not appear on instr.
